// File: rtl/rx_frame_parser_if.sv
// rtl/rx_frame_parser_if.sv - rx byte stream, payload write port and parsed header bundle
interface rx_frame_parser_if #(
  parameter int AW = 11,
  parameter int DW = 8,
  parameter int WW = 16
);
  logic          rx_valid;
  logic          rx_sof;
  logic [DW-1:0] rx_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          newpkt;
  logic [2:0]    fPktType;
  logic [WW-1:0] sourceID;
  logic [WW-1:0] destinationID;
  logic [7:0]    hopCount;
  logic [7:0]    payloadLen;
  logic          pktErr;
  logic [7:0]    errCount;

  modport master (
    output rx_valid, rx_sof, rx_data,
    input  mem_we, mem_addr, mem_wdata, newpkt, fPktType, sourceID,
           destinationID, hopCount, payloadLen, pktErr, errCount
  );

  modport slave (
    input  rx_valid, rx_sof, rx_data,
    output mem_we, mem_addr, mem_wdata, newpkt, fPktType, sourceID,
           destinationID, hopCount, payloadLen, pktErr, errCount
  );
endinterface

// File: rtl/rx_frame_parser.sv
// rtl/rx_frame_parser.sv - frames the radio byte stream, checks XOR checksum, writes payload
module rx_frame_parser #(
  parameter int MEM_DEPTH    = 2048,
  parameter int MEM_WIDTH    = 8,
  parameter int WORD_WIDTH   = 16,
  parameter int MAX_PAYLOAD  = 32,
  parameter int PAYLOAD_BASE = 0,
  parameter int TIMEOUT_CYC  = 64
) (
  input logic               clk,
  input logic               rst,
  rx_frame_parser_if.slave  bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CSUM, DROP} state_t;

  state_t                r_state;
  logic [2:0]            r_hdr_cnt;
  logic [7:0]            r_b0, r_hop, r_len, r_idx, r_err_cnt;
  logic [MEM_WIDTH-1:0]  r_xor;
  logic [WORD_WIDTH-1:0] r_src, r_dst;
  logic [TW-1:0]         r_tmo;

  logic                  r_mem_we, r_newpkt, r_pkt_err;
  logic [AW-1:0]         r_mem_addr;
  logic [MEM_WIDTH-1:0]  r_mem_wdata;
  logic [2:0]            r_o_type;
  logic [WORD_WIDTH-1:0] r_o_src, r_o_dst;
  logic [7:0]            r_o_hop, r_o_len;

  logic w_in_frame, w_sof, w_byte, w_abort, w_timeout, w_bad_hdr;
  logic w_csum_ok, w_csum_bad, w_err;
  logic [AW-1:0] w_addr;

  assign w_in_frame = (r_state == HDR) || (r_state == PAYLOAD) || (r_state == CSUM);
  assign w_sof      = bus.rx_valid && bus.rx_sof;
  assign w_byte     = bus.rx_valid && !bus.rx_sof;
  assign w_abort    = w_sof && (r_state != IDLE);
  assign w_timeout  = w_in_frame && !bus.rx_valid && (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_bad_hdr  = (r_state == HDR) && w_byte && (r_hdr_cnt == 3'd6) &&
                      ((bus.rx_data > MEM_WIDTH'(MAX_PAYLOAD)) || (r_b0[7:3] != 5'd0) ||
                       (r_b0[2:0] == 3'b111));
  assign w_csum_ok  = (r_state == CSUM) && w_byte && (bus.rx_data == r_xor);
  assign w_csum_bad = (r_state == CSUM) && w_byte && (bus.rx_data != r_xor);
  // A new sof while discarding a dropped frame is the expected recovery path, not an error.
  assign w_err      = (w_abort && (r_state != DROP)) || w_timeout || w_bad_hdr || w_csum_bad;
  assign w_addr     = AW'(PAYLOAD_BASE) + AW'(r_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hdr_cnt   <= '0;
      r_b0        <= '0;
      r_hop       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_err_cnt   <= '0;
      r_xor       <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_tmo       <= '0;
      r_mem_we    <= 1'b0;
      r_newpkt    <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_o_type    <= 3'b111;
      r_o_src     <= '0;
      r_o_dst     <= '0;
      r_o_hop     <= '0;
      r_o_len     <= '0;
    end else begin
      r_mem_we  <= 1'b0;
      r_newpkt  <= w_csum_ok;
      r_pkt_err <= w_err;
      if (w_err && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
      if (w_csum_ok) begin
        r_o_type <= r_b0[2:0];
        r_o_src  <= r_src;
        r_o_dst  <= r_dst;
        r_o_hop  <= r_hop;
        r_o_len  <= r_len;
      end
      if (bus.rx_valid || !w_in_frame)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + TW'(1);

      if (w_sof) begin
        r_state   <= HDR;
        r_hdr_cnt <= 3'd1;
        r_b0      <= bus.rx_data;
        r_xor     <= bus.rx_data;
        r_idx     <= '0;
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          HDR: begin
            if (w_timeout) begin
              r_state <= IDLE;
            end else if (w_byte) begin
              r_xor <= r_xor ^ bus.rx_data;
              case (r_hdr_cnt)
                3'd1, 3'd2: r_src <= {r_src[WORD_WIDTH-MEM_WIDTH-1:0], bus.rx_data};
                3'd3, 3'd4: r_dst <= {r_dst[WORD_WIDTH-MEM_WIDTH-1:0], bus.rx_data};
                3'd5:       r_hop <= bus.rx_data;
                default:    r_len <= bus.rx_data;
              endcase
              if (r_hdr_cnt == 3'd6) begin
                if (w_bad_hdr)
                  r_state <= DROP;
                else if (bus.rx_data == '0)
                  r_state <= CSUM;
                else
                  r_state <= PAYLOAD;
              end else begin
                r_hdr_cnt <= r_hdr_cnt + 3'd1;
              end
            end
          end
          PAYLOAD: begin
            if (w_timeout) begin
              r_state <= IDLE;
            end else if (w_byte) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_addr;
              r_mem_wdata <= bus.rx_data;
              r_xor       <= r_xor ^ bus.rx_data;
              r_idx       <= r_idx + 8'd1;
              if (r_idx + 8'd1 == r_len)
                r_state <= CSUM;
            end
          end
          CSUM: begin
            if (w_timeout || w_byte)
              r_state <= IDLE;
          end
          DROP:    r_state <= DROP;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.newpkt        = r_newpkt;
  assign bus.pktErr        = r_pkt_err;
  assign bus.errCount      = r_err_cnt;
  assign bus.fPktType      = r_o_type;
  assign bus.sourceID      = r_o_src;
  assign bus.destinationID = r_o_dst;
  assign bus.hopCount      = r_o_hop;
  assign bus.payloadLen    = r_o_len;
endmodule

// File: tb/tb_rx_frame_parser.sv
// tb/tb_rx_frame_parser.sv - scoreboard bench for rx_frame_parser with directed frames
module tb_rx_frame_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_frame_parser_if bus_if ();
  rx_frame_parser dut (.clk(clk), .rst(rst), .bus(bus_if));

  typedef struct {
    int          kind;  // 0 payload write, 1 newpkt, 2 pktErr
    logic [10:0] addr;
    logic [7:0]  data;
    logic [2:0]  typ;
    logic [15:0] src, dst;
    logic [7:0]  hop, len, errc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  logic [2:0]  m_type = 3'b111;
  logic [15:0] m_src = 0, m_dst = 0;
  logic [7:0]  m_hop = 0, m_len = 0;
  int          m_err = 0;

  logic [7:0] hb[]     = '{8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h01, 8'h00, 8'h04};
  logic [7:0] hb_bad[] = '{8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h01, 8'h00, 8'h05};
  logic [7:0] ch[]     = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h0C, 8'h01, 8'h03,
                           8'hAA, 8'hBB, 8'hCC, 8'hD7};
  logic [7:0] f2[]     = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h07, 8'h00, 8'h45};
  logic [7:0] n33[]    = '{8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h01, 8'h21};
  logic [7:0] t07[]    = '{8'h07, 8'h00, 8'h05, 8'h00, 8'h00, 8'h01, 8'h00};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic exp_t mk(input int kind);
    exp_t e;
    e.kind = kind; e.addr = '0; e.data = '0;
    e.typ = m_type; e.src = m_src; e.dst = m_dst; e.hop = m_hop; e.len = m_len;
    e.errc = 8'(m_err);
    return e;
  endfunction

  task automatic exp_wr(input logic [10:0] a, input logic [7:0] d);
    exp_t e;
    e = mk(0); e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic exp_good(input logic [2:0] t, input logic [15:0] s, input logic [15:0] d,
                          input logic [7:0] h, input logic [7:0] l);
    m_type = t; m_src = s; m_dst = d; m_hop = h; m_len = l;
    q.push_back(mk(1));
  endtask

  task automatic exp_err();
    if (m_err < 255) m_err++;
    q.push_back(mk(2));
  endtask

  task automatic take(input int kind);
    exp_t e;
    n_chk++;
    if (q.size() == 0) begin
      $display("FAIL unexpected_event: kind %0d seen, none expected", kind);
      return;
    end
    n_pass++;
    e = q.pop_front();
    check("event_kind", 64'(kind), 64'(e.kind));
    if (kind == 0)
      check("mem_write", {bus_if.mem_addr, bus_if.mem_wdata}, {e.addr, e.data});
    else
      check(kind == 1 ? "newpkt_fields" : "pktErr_fields",
            {bus_if.fPktType, bus_if.sourceID, bus_if.destinationID, bus_if.hopCount,
             bus_if.payloadLen, bus_if.errCount},
            {e.typ, e.src, e.dst, e.hop, e.len, e.errc});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_if.newpkt || bus_if.pktErr)
          check("newpkt_pktErr_exclusive", 64'(bus_if.newpkt & bus_if.pktErr), 64'd0);
        if (bus_if.mem_we) take(0);
        if (bus_if.newpkt) take(1);
        if (bus_if.pktErr) take(2);
      end
    end
  end

  task automatic send(input bit sof, input logic [7:0] d);
    @(negedge clk);
    bus_if.rx_valid = 1'b1; bus_if.rx_sof = sof; bus_if.rx_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_if.rx_valid = 1'b0; bus_if.rx_sof = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] f[], input int gap);
    for (int i = 0; i < f.size(); i++) begin
      send(i == 0, f[i]);
      if (gap > 0 && i != f.size() - 1) idle(gap);
    end
    idle(1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"},
          {bus_if.newpkt, bus_if.pktErr, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata},
          {1'b0, 1'b0, 1'b0, 11'd0, 8'd0});
    check({tag, "_hdr"},
          {bus_if.fPktType, bus_if.sourceID, bus_if.destinationID, bus_if.hopCount,
           bus_if.payloadLen, bus_if.errCount},
          {3'b111, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0});
  endtask

  initial begin
    bus_if.rx_valid = 1'b0; bus_if.rx_sof = 1'b0; bus_if.rx_data = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    idle(2);

    exp_good(3'd0, 16'h0005, 16'h0000, 8'h01, 8'h00);
    send_frame(hb, 0);
    idle(2);

    exp_wr(11'd0, 8'hAA); exp_wr(11'd1, 8'hBB); exp_wr(11'd2, 8'hCC);
    exp_good(3'd1, 16'h0005, 16'h000C, 8'h01, 8'h03);
    send_frame(ch, 0);
    idle(2);

    exp_err();
    send_frame(hb_bad, 0);
    idle(2);

    exp_err();
    send_frame(n33, 0);
    send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); idle(1);
    exp_good(3'd0, 16'h0005, 16'h0000, 8'h01, 8'h00);
    send_frame(hb, 0);
    idle(2);

    exp_err();
    send_frame(t07, 0);
    send(0, 8'h04); send(0, 8'h55); idle(1);
    exp_good(3'd2, 16'h1234, 16'hABCD, 8'h07, 8'h00);
    send_frame(f2, 0);
    idle(2);

    exp_err();
    send(1, 8'h00); send(0, 8'h00); send(0, 8'h05); send(0, 8'h00);
    exp_good(3'd0, 16'h0005, 16'h0000, 8'h01, 8'h00);
    send_frame(hb, 0);
    idle(2);

    exp_err();
    send(1, 8'h00); send(0, 8'h00); send(0, 8'h05);
    idle(64);
    send(0, 8'h77); idle(3);

    exp_good(3'd2, 16'h1234, 16'hABCD, 8'h07, 8'h00);
    send_frame(f2, 63);
    idle(2);

    exp_wr(11'd0, 8'hAA); exp_wr(11'd1, 8'hBB);
    for (int i = 0; i < 9; i++) send(i == 0, ch[i]);
    idle(1);
    #2;
    check("queue_drained_before_reset", 64'(q.size()), 64'd0);
    rst = 1'b1;
    #1;
    m_type = 3'b111; m_src = 0; m_dst = 0; m_hop = 0; m_len = 0; m_err = 0;
    check_reset_values("async_reset");
    idle(2);
    rst = 1'b0;
    idle(1);
    exp_good(3'd0, 16'h0005, 16'h0000, 8'h01, 8'h00);
    send_frame(hb, 0);
    idle(2);

    for (int i = 0; i < 301; i++) begin
      if (i > 0) exp_err();
      send(1, 8'h00);
    end
    exp_err();
    idle(70);
    check("errCount_saturated", 64'(bus_if.errCount), 64'd255);
    check("queue_empty_at_end", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
